// File: rtl/ctrl_data_drain.sv
// ctrl_data_drain
//   Drains the ctrl/data FIFO pair into a valid/ready stream. Pops are issued only while
//   running and only when the output buffer has room for every read still in flight.
//   This lets the FIFO read latency be absorbed without back-pressuring the FIFO read path.
//   Dropping enable stops new pops. Reads already in flight are still captured and delivered
//   before the block returns to idle.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   enable           1 = run, 0 = stop popping and drain
//   fifo_dout        {ctrl, data} returned by the FIFO
//   fifo_valid       one pulse per pop, READ_LATENCY cycles after the pop
//   fifo_empty       FIFO empty flag
//   fifo_shift_out   pop request (combinational)
//   m_data/m_ctrl    stream payload from the buffer head
//   m_last           m_ctrl[LAST_BIT]
//   m_valid/m_ready  stream handshake
//   busy             FSM not idle
//   err_unexpected   sticky: fifo_valid seen with no read in flight
//
// Optional feature (macro CTRL_DATA_DRAIN_STATS_EN)
//   stat_beats, stat_pkts: wrapping counts of accepted beats and of accepted beats with m_last.
//
// state | meaning
// IDLE  | nothing in flight, buffer empty, no pops
// RUN   | issuing pops while credit allows
// DRAIN | no new pops; waiting for in-flight reads and buffer to empty

module ctrl_data_drain #(
  parameter int DATA_WIDTH   = 32,
  parameter int CTRL_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int LAST_BIT     = 0,
  parameter int BUF_DEPTH    = READ_LATENCY + 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] fifo_dout,
  input  logic                             fifo_valid,
  input  logic                             fifo_empty,
  output logic                             fifo_shift_out,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [CTRL_WIDTH-1:0]            m_ctrl,
  output logic                             m_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             busy,
  output logic                             err_unexpected
`ifdef CTRL_DATA_DRAIN_STATS_EN
  ,
  output logic [31:0]                      stat_beats,
  output logic [31:0]                      stat_pkts
`endif
);

  localparam int EW = DATA_WIDTH + CTRL_WIDTH;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW:0]   LP_DEPTH    = (CW + 1)'(BUF_DEPTH);
  localparam logic [PW-1:0] LP_LAST_PTR = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state;
  logic [EW-1:0] r_mem [BUF_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_inflight;
  logic          r_err;

  logic          w_pop;
  logic          w_cap;
  logic          w_stray;
  logic          w_deq;
  logic [CW:0]   w_credit;
  logic [EW-1:0] w_head;

  // Every outstanding read owns a buffer slot, so a capture can never find the buffer full
  // unless the same cycle also dequeues.
  assign w_credit = {1'b0, r_inflight} + {1'b0, r_occ};
  // Gating with enable stops pops in the same cycle enable falls, not one cycle later.
  assign w_pop    = (r_state == S_RUN) && enable && !fifo_empty && (w_credit < LP_DEPTH);
  assign w_cap    = fifo_valid && (r_inflight != '0);
  assign w_stray  = fifo_valid && (r_inflight == '0);
  assign m_valid  = (r_occ != '0);
  assign w_deq    = m_valid && m_ready;

  assign w_head         = r_mem[r_rd_ptr];
  assign m_data         = w_head[DATA_WIDTH-1:0];
  assign m_ctrl         = w_head[EW-1:DATA_WIDTH];
  assign m_last         = m_ctrl[LAST_BIT];
  assign fifo_shift_out = w_pop;
  assign busy           = (r_state != S_IDLE);
  assign err_unexpected = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (enable) r_state <= S_RUN;
        S_RUN:   if (!enable) r_state <= S_DRAIN;
        S_DRAIN: begin
          if (enable)                                    r_state <= S_RUN;
          else if ((r_inflight == '0) && (r_occ == '0))  r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_cap) begin
        r_mem[r_wr_ptr] <= fifo_dout;
        r_wr_ptr        <= (r_wr_ptr == LP_LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= (r_rd_ptr == LP_LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_cap, w_deq})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
      case ({w_pop, w_cap})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_stray) r_err <= 1'b1;
    end
  end

`ifdef CTRL_DATA_DRAIN_STATS_EN
  logic [31:0] r_stat_beats;
  logic [31:0] r_stat_pkts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_beats <= '0;
      r_stat_pkts  <= '0;
    end else if (w_deq) begin
      r_stat_beats <= r_stat_beats + 32'd1;
      if (m_last) r_stat_pkts <= r_stat_pkts + 32'd1;
    end
  end

  assign stat_beats = r_stat_beats;
  assign stat_pkts  = r_stat_pkts;
`endif

endmodule

// File: tb/tb_ctrl_data_drain.sv
// Scoreboard bench for ctrl_data_drain: a FIFO model with configurable read latency feeds
// the DUT, every entry loaded into the FIFO is also queued as the expected beat, and a
// monitor compares each accepted beat against the head of that queue.
`timescale 1ns/1ps
module tb_ctrl_data_drain;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam int RL = 3;
  localparam int LB = 0;
  localparam int BD = 5;
  localparam int EW = DW + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [EW-1:0] fifo_dout = '0;
  logic          fifo_valid = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_shift_out;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_ctrl;
  logic          m_last;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          err_unexpected;
`ifdef CTRL_DATA_DRAIN_STATS_EN
  logic [31:0]   stat_beats;
  logic [31:0]   stat_pkts;
`endif

  ctrl_data_drain #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .READ_LATENCY(RL), .LAST_BIT(LB), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fifo_dout(fifo_dout), .fifo_valid(fifo_valid), .fifo_empty(fifo_empty),
    .fifo_shift_out(fifo_shift_out),
    .m_data(m_data), .m_ctrl(m_ctrl), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .err_unexpected(err_unexpected)
`ifdef CTRL_DATA_DRAIN_STATS_EN
    , .stat_beats(stat_beats), .stat_pkts(stat_pkts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pop_total = 0;
  int beat_cnt = 0;
  int beat_cyc_q[$];
  logic [EW-1:0] fifo_q[$];
  logic [EW-1:0] exp_q[$];
  logic [RL-1:0] pv = '0;
  logic [EW-1:0] pd [RL] = '{default: '0};
  logic          pop_s = 1'b0;
  logic          inj = 1'b0;
  logic [EW-1:0] inj_data = '0;
  logic          hold_pending = 1'b0;
  logic [EW:0]   held = '0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // FIFO model: a pop registered at edge e returns its entry on fifo_valid so that it is
  // captured at edge e+RL.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    pv = {1'b0, pv[RL-1:1]};
    for (int i = 0; i < RL - 1; i++) pd[i] = pd[i+1];
    pd[RL-1] = '0;
    if (pop_s) begin
      if (fifo_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_on_empty actual=pop required=no_pop");
      end else begin
        pv[RL-1] = 1'b1;
        pd[RL-1] = fifo_q.pop_front();
      end
    end
    fifo_valid = pv[0] | inj;
    fifo_dout  = inj ? inj_data : pd[0];
    fifo_empty = (fifo_q.size() == 0);
  end

  // Monitor: samples pops and beats on the falling edge.
  initial forever begin
    @(negedge clk or posedge rst);
    pop_s = fifo_shift_out;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (fifo_shift_out) pop_total++;
      if (hold_pending) begin
        chk("hold_stable", {m_valid, m_ctrl, m_data}, held);
        hold_pending = 1'b0;
      end
      if (m_valid) begin
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL beat_unexpected actual=%0h required=none", {m_ctrl, m_data});
          end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            chk("beat_data", {m_ctrl, m_data}, e);
            chk("beat_last", m_last, e[DW+LB]);
          end
          beat_cnt++;
          beat_cyc_q.push_back(cyc);
        end else begin
          hold_pending = 1'b1;
          held = {1'b1, m_ctrl, m_data};
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int n, input int last_mode);
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      c = $urandom();
      d = $urandom();
      if (last_mode == 1) c[LB] = (i % 4 == 3);
      fifo_q.push_back({c, d});
      exp_q.push_back({c, d});
    end
  endtask

  task automatic wait_drained(input string name, input int maxc);
    for (int k = 0; k < maxc && exp_q.size() != 0; k++) sample();
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    for (int k = 0; k < maxc && busy; k++) sample();
    chk(name, busy, 0);
  endtask

  initial begin
    int t0, t1, p0, b0, mv_seen;
    bit found;
`ifdef CTRL_DATA_DRAIN_STATS_EN
    logic [31:0] sb0, sp0;
`endif
    repeat (2) @(posedge clk);
    sample();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_shift", fifo_shift_out, 0);
    chk("rst_err", err_unexpected, 0);
    tick();
    rst = 1'b0;

    // Four entries, ready held high: latency and back-to-back delivery.
    load(4, 0);
    m_ready = 1'b1;
    enable = 1'b1;
    beat_cyc_q.delete();
    found = 0;
    t0 = 0;
    t1 = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      sample();
      if (fifo_shift_out) begin found = 1; t0 = cyc; end
    end
    chk("t1_first_pop_seen", found, 1);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_valid) begin found = 1; t1 = cyc; end
      else sample();
    end
    chk("t1_latency", t1 - t0, RL + 1);
    wait_drained("t1_drain", 50);
    chk("t1_beat_count", beat_cyc_q.size(), 4);
    if (beat_cyc_q.size() == 4) chk("t1_consecutive", beat_cyc_q[3] - beat_cyc_q[0], 3);
    tick();
    enable = 1'b0;
    wait_idle("t1_idle", 20);

    // Ready low: pops must stop at the buffer depth, head held.
    tick();
    m_ready = 1'b0;
    load(10, 0);
    p0 = pop_total;
    enable = 1'b1;
    repeat (25) sample();
    chk("t2_pops_credit", pop_total - p0, BD);
    chk("t2_valid_held", m_valid, 1);
    tick();
    m_ready = 1'b1;
    wait_drained("t2_drain", 100);
    chk("t2_pops_total", pop_total - p0, 10);
    tick();
    enable = 1'b0;
    wait_idle("t2_idle", 20);

    // Enable dropped right after the first pop.
    load(3, 0);
    p0 = pop_total;
    tick();
    m_ready = 1'b1;
    enable = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      sample();
      if (fifo_shift_out) found = 1;
    end
    chk("t3_pop_seen", found, 1);
    tick();
    enable = 1'b0;
    b0 = beat_cnt;
    for (int k = 0; k < 20 && beat_cnt == b0; k++) sample();
    chk("t3_beat_delivered", beat_cnt - b0, 1);
    chk("t3_busy_at_accept", busy, 1);
    wait_idle("t3_busy_fall", 5);
    chk("t3_single_pop", pop_total - p0, 1);
    chk("t3_left_in_fifo", fifo_q.size(), 2);
    fifo_q.delete();
    exp_q.delete();

    // Three packets of four beats, last bit on every fourth beat.
`ifdef CTRL_DATA_DRAIN_STATS_EN
    sb0 = stat_beats;
    sp0 = stat_pkts;
`endif
    tick();
    load(12, 1);
    enable = 1'b1;
    wait_drained("t4_drain", 100);
    tick();
    enable = 1'b0;
    wait_idle("t4_idle", 20);
`ifdef CTRL_DATA_DRAIN_STATS_EN
    chk("t4_stat_beats", stat_beats - sb0, 12);
    chk("t4_stat_pkts", stat_pkts - sp0, 3);
`endif

    // Random ready/enable traffic.
    load(40, 2);
    found = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      tick();
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 7) != 0);
      if (exp_q.size() == 0) found = 1;
    end
    chk("rnd_drain", exp_q.size(), 0);
    tick();
    enable = 1'b0;
    m_ready = 1'b1;
    wait_idle("rnd_idle", 20);
    chk("rnd_no_err", err_unexpected, 0);

    // Stray fifo_valid while idle.
    sample();
    inj_data = {$urandom(), $urandom()};
    inj = 1'b1;
    @(posedge clk);
    #2;
    inj = 1'b0;
    repeat (3) sample();
    chk("t5_err_set", err_unexpected, 1);
    chk("t5_no_valid", m_valid, 0);
    chk("t5_busy", busy, 0);

    // Reset with entries buffered and reads in flight.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    chk("t6_err_cleared", err_unexpected, 0);
    tick();
    m_ready = 1'b0;
    load(10, 0);
    p0 = pop_total;
    enable = 1'b1;
    for (int k = 0; k < 30 && (pop_total - p0) < 5; k++) sample();
    chk("t6_five_pops", pop_total - p0, 5);
    @(posedge clk);
    #2;
    chk("t6_valid_before_rst", m_valid, 1);
    rst = 1'b1;
    enable = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    #1;
    chk("t6_rst_m_valid", m_valid, 0);
    chk("t6_rst_busy", busy, 0);
    #1;
    rst = 1'b0;
    mv_seen = 0;
    repeat (8) begin
      sample();
      if (m_valid) mv_seen = 1;
    end
    chk("t6_no_valid_after_rst", mv_seen, 0);
    chk("t6_late_err", err_unexpected, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
